// File: rtl/bin_frame_pkg.sv
// Shared types, sizes and magnitude/decay helpers for the spectrum bin frame writer.
// Imported by the writer top level and by each peak-hold cell.
package bin_frame_pkg;

    localparam int NUM_BINS = 16;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Absolute value clamped to 0..32767 so -32768 cannot wrap to a negative bar.
    function automatic logic [15:0] sat_abs16(input logic signed [15:0] v);
        logic [15:0] r;
        if (v == -16'sd32768) begin
            r = 16'd32767;
        end else if (v < 16'sd0) begin
            r = -v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [15:0] decay_sat(input logic [15:0] cur, input logic [15:0] dec);
        logic [15:0] r;
        if (cur > dec) begin
            r = cur - dec;
        end else begin
            r = 16'd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_frame_writer_if.sv
// Valid/ready stream carrying one indexed signed bin result per beat.
// The transform stage is the master and the frame writer is the slave.
interface bin_frame_writer_if;
    logic        bin_valid;
    logic        bin_ready;
    logic [3:0]  bin_idx;
    logic [15:0] bin_data;

    modport master (output bin_valid, output bin_idx, output bin_data, input bin_ready);
    modport slave  (input bin_valid, input bin_idx, input bin_data, output bin_ready);
endinterface

// File: rtl/bin_peak_cell.sv
// One displayed bar: holds its peak and, on commit, keeps the larger of the new
// staged magnitude and the previous peak reduced by the decay step.
module bin_peak_cell
    import bin_frame_pkg::*;
(
    input  logic        clk50,
    input  logic        rst_n,
    input  logic [15:0] staged,
    input  logic        commit,
    input  logic [15:0] decay,
    output logic [15:0] f
);

    logic [15:0] f_r;
    logic [15:0] decayed_s;
    logic [15:0] next_s;

    // Candidate peak: max of fresh magnitude and decayed hold value.
    always_comb begin
        decayed_s = decay_sat(f_r, decay);
        if (staged > decayed_s) begin
            next_s = staged;
        end else begin
            next_s = decayed_s;
        end
    end

    // Peak register, updated only on the frame commit strobe.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            f_r <= 16'd0;
        end else if (commit) begin
            f_r <= next_s;
        end else begin
            f_r <= f_r;
        end
    end

    assign f = f_r;

endmodule

// File: rtl/bin_frame_writer.sv
// Collects sixteen in-order bin results into a staging frame and commits them all
// to the peak-hold bars on the first vsync falling edge after the frame completes.
module bin_frame_writer
    import bin_frame_pkg::*;
#(
    parameter logic [15:0] DECAY = 16'd512
) (
    input  logic                clk50,
    input  logic                rst_n,
    bin_frame_writer_if.slave   bin,
    input  logic                vsync,
    output logic [15:0]         f0,
    output logic [15:0]         f1,
    output logic [15:0]         f2,
    output logic [15:0]         f3,
    output logic [15:0]         f4,
    output logic [15:0]         f5,
    output logic [15:0]         f6,
    output logic [15:0]         f7,
    output logic [15:0]         f8,
    output logic [15:0]         f9,
    output logic [15:0]         f10,
    output logic [15:0]         f11,
    output logic [15:0]         f12,
    output logic [15:0]         f13,
    output logic [15:0]         f14,
    output logic [15:0]         f15,
    output logic                done,
    output logic                err
);

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  exp_r;
    logic [15:0] staging_r [NUM_BINS];
    logic [15:0] f_s [NUM_BINS];
    logic        vsync_d_r;
    logic        done_r;
    logic        err_r;
    logic        bin_ready_s;
    logic        beat_s;
    logic        in_order_s;
    logic        vsync_fall_s;
    logic        commit_s;
    logic [15:0] mag_s;

    assign beat_s       = bin.bin_valid && bin_ready_s;
    assign in_order_s   = (bin.bin_idx == exp_r);
    assign vsync_fall_s = !vsync && vsync_d_r;
    assign commit_s     = (state_r == PENDING) && vsync_fall_s;
    assign mag_s        = sat_abs16($signed(bin.bin_data));

    // FSM state register.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= COLLECT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: a vsync edge coinciding with the last beat is not a commit.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            COLLECT: begin
                if (beat_s && in_order_s && (exp_r == 4'd15)) begin
                    state_next_s = PENDING;
                end else begin
                    state_next_s = COLLECT;
                end
            end
            PENDING: begin
                if (vsync_fall_s) begin
                    state_next_s = COLLECT;
                end else begin
                    state_next_s = PENDING;
                end
            end
            default: state_next_s = COLLECT;
        endcase
    end

    // FSM outputs: ready depends on state alone.
    always_comb begin
        bin_ready_s = 1'b0;
        case (state_r)
            COLLECT: bin_ready_s = 1'b1;
            PENDING: bin_ready_s = 1'b0;
            default: bin_ready_s = 1'b0;
        endcase
    end

    assign bin.bin_ready = bin_ready_s;

    // Expected index and staging; an out-of-order index 0 restarts the frame with itself.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            exp_r <= 4'd0;
            for (int i = 0; i < NUM_BINS; i++) begin
                staging_r[i] <= 16'd0;
            end
        end else if (beat_s) begin
            if (in_order_s) begin
                staging_r[exp_r] <= mag_s;
                exp_r            <= exp_r + 4'd1;
            end else if (bin.bin_idx == 4'd0) begin
                staging_r[0] <= mag_s;
                exp_r        <= 4'd1;
            end else begin
                exp_r <= 4'd0;
            end
        end else if (commit_s) begin
            exp_r <= 4'd0;
        end else begin
            exp_r <= exp_r;
        end
    end

    // Vsync history for edge detection, plus sticky done and the error pulse.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d_r <= 1'b1;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            vsync_d_r <= vsync;
            done_r    <= done_r | commit_s;
            err_r     <= beat_s && !in_order_s;
        end
    end

    for (genvar k = 0; k < NUM_BINS; k++) begin : g_cell
        bin_peak_cell u_cell (
            .clk50  (clk50),
            .rst_n  (rst_n),
            .staged (staging_r[k]),
            .commit (commit_s),
            .decay  (DECAY),
            .f      (f_s[k])
        );
    end

    assign f0   = f_s[0];
    assign f1   = f_s[1];
    assign f2   = f_s[2];
    assign f3   = f_s[3];
    assign f4   = f_s[4];
    assign f5   = f_s[5];
    assign f6   = f_s[6];
    assign f7   = f_s[7];
    assign f8   = f_s[8];
    assign f9   = f_s[9];
    assign f10  = f_s[10];
    assign f11  = f_s[11];
    assign f12  = f_s[12];
    assign f13  = f_s[13];
    assign f14  = f_s[14];
    assign f15  = f_s[15];
    assign done = done_r;
    assign err  = err_r;

endmodule

// File: tb/tb_bin_frame_writer.sv
// Directed bench for bin_frame_writer: frame commit, peak decay, saturation,
// sequence errors, last-beat/vsync coincidence and reset while pending.
module tb_bin_frame_writer;

    logic        clk50;
    logic        rst_n;
    logic        vsync;
    logic        done;
    logic        err;
    logic [15:0] f [16];
    int          n_checks;
    int          n_errs;

    bin_frame_writer_if bin_if ();

    bin_frame_writer #(.DECAY(16'd512)) dut (
        .clk50 (clk50),
        .rst_n (rst_n),
        .bin   (bin_if.slave),
        .vsync (vsync),
        .f0  (f[0]),  .f1  (f[1]),  .f2  (f[2]),  .f3  (f[3]),
        .f4  (f[4]),  .f5  (f[5]),  .f6  (f[6]),  .f7  (f[7]),
        .f8  (f[8]),  .f9  (f[9]),  .f10 (f[10]), .f11 (f[11]),
        .f12 (f[12]), .f13 (f[13]), .f14 (f[14]), .f15 (f[15]),
        .done  (done),
        .err   (err)
    );

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic send_beat(input logic [3:0] idx, input logic [15:0] data);
        @(negedge clk50);
        bin_if.bin_valid = 1'b1;
        bin_if.bin_idx   = idx;
        bin_if.bin_data  = data;
        @(posedge clk50);
        #1;
        bin_if.bin_valid = 1'b0;
    endtask

    task automatic vsync_fall();
        @(negedge clk50);
        vsync = 1'b0;
        @(posedge clk50);
        #1;
    endtask

    task automatic vsync_rise();
        @(negedge clk50);
        vsync = 1'b1;
        @(posedge clk50);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [15:0] exp_v [16]);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s_f%0d", tag, k), {16'd0, f[k]}, {16'd0, exp_v[k]});
        end
    endtask

    task automatic do_reset();
        @(negedge clk50);
        rst_n = 1'b0;
        @(negedge clk50);
        rst_n = 1'b1;
    endtask

    logic [15:0] e [16];

    initial begin
        n_checks = 0;
        n_errs   = 0;
        rst_n    = 1'b0;
        vsync    = 1'b1;
        bin_if.bin_valid = 1'b0;
        bin_if.bin_idx   = 4'd0;
        bin_if.bin_data  = 16'd0;
        #35;
        rst_n = 1'b1;
        @(negedge clk50);

        // Reset state
        chk("rst_ready", {31'd0, bin_if.bin_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_f0", {16'd0, f[0]}, 32'd0);

        // Frame 100*(k+1), ready low while pending
        for (int k = 0; k < 16; k++) begin
            send_beat(4'(k), 16'(100 * (k + 1)));
        end
        chk("pend_ready", {31'd0, bin_if.bin_ready}, 32'd0);
        repeat (3) @(posedge clk50);
        #1;
        chk("pend_ready_hold", {31'd0, bin_if.bin_ready}, 32'd0);
        chk("pend_f5", {16'd0, f[5]}, 32'd0);
        vsync_fall();
        for (int k = 0; k < 16; k++) e[k] = 16'(100 * (k + 1));
        check_all("ramp", e);
        chk("ramp_done", {31'd0, done}, 32'd1);
        chk("ramp_ready", {31'd0, bin_if.bin_ready}, 32'd1);
        vsync_rise();

        // Frame A all 16000, then frame B all 0 committed, then ignored vsync
        for (int k = 0; k < 16; k++) send_beat(4'(k), 16'd16000);
        vsync_fall();
        vsync_rise();
        for (int k = 0; k < 16; k++) e[k] = 16'd16000;
        check_all("frameA", e);
        for (int k = 0; k < 16; k++) send_beat(4'(k), 16'd0);
        vsync_fall();
        vsync_rise();
        for (int k = 0; k < 16; k++) e[k] = 16'd15488;
        check_all("frameB", e);
        vsync_fall();
        vsync_rise();
        check_all("idle_vsync", e);
        chk("idle_done", {31'd0, done}, 32'd1);

        // Saturation from a clean reset: -32768 -> 32767, -480 -> 480
        do_reset();
        for (int k = 0; k < 16; k++) begin
            if (k == 3) send_beat(4'(k), 16'h8000);
            else if (k == 10) send_beat(4'(k), -16'sd480);
            else send_beat(4'(k), 16'd0);
        end
        vsync_fall();
        vsync_rise();
        for (int k = 0; k < 16; k++) e[k] = 16'd0;
        e[3]  = 16'd32767;
        e[10] = 16'd480;
        check_all("sat", e);

        // Sequence error: 0,1,2 then 5
        send_beat(4'd0, 16'd7000);
        send_beat(4'd1, 16'd7000);
        send_beat(4'd2, 16'd7000);
        chk("seq_noerr", {31'd0, err}, 32'd0);
        send_beat(4'd5, 16'd7000);
        chk("seq_err_pulse", {31'd0, err}, 32'd1);
        @(posedge clk50);
        #1;
        chk("seq_err_clear", {31'd0, err}, 32'd0);
        chk("seq_ready", {31'd0, bin_if.bin_ready}, 32'd1);
        vsync_fall();
        vsync_rise();
        check_all("seq_nocommit", e);
        for (int k = 0; k < 16; k++) send_beat(4'(k), 16'd200);
        chk("seq_clean_pend", {31'd0, bin_if.bin_ready}, 32'd0);
        vsync_fall();
        vsync_rise();
        for (int k = 0; k < 16; k++) e[k] = 16'd200;
        e[3] = 16'd32255;
        check_all("seq_clean", e);

        // Last beat coincides with vsync fall: no commit until the next fall
        for (int k = 0; k < 15; k++) send_beat(4'(k), 16'd300);
        @(negedge clk50);
        bin_if.bin_valid = 1'b1;
        bin_if.bin_idx   = 4'd15;
        bin_if.bin_data  = 16'd300;
        vsync            = 1'b0;
        @(posedge clk50);
        #1;
        bin_if.bin_valid = 1'b0;
        chk("coin_ready", {31'd0, bin_if.bin_ready}, 32'd0);
        check_all("coin_hold", e);
        vsync_rise();
        vsync_fall();
        for (int k = 0; k < 16; k++) e[k] = 16'd300;
        e[3] = 16'd31743;
        check_all("coin_commit", e);
        vsync_rise();

        // Reset while pending
        for (int k = 0; k < 16; k++) send_beat(4'(k), 16'd5000);
        chk("rstp_pend", {31'd0, bin_if.bin_ready}, 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstp_f0", {16'd0, f[0]}, 32'd0);
        chk("rstp_f3", {16'd0, f[3]}, 32'd0);
        chk("rstp_done", {31'd0, done}, 32'd0);
        chk("rstp_ready", {31'd0, bin_if.bin_ready}, 32'd1);
        @(negedge clk50);
        rst_n = 1'b1;
        vsync_fall();
        vsync_rise();
        for (int k = 0; k < 16; k++) e[k] = 16'd0;
        check_all("rstp_nocommit", e);
        chk("rstp_done_after", {31'd0, done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
